// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle sequencer.
// States, opcode classes, opcode values and ALU operation codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_R    = 2'd1,
      CLS_I    = 2'd2,
      CLS_ILL  = 2'd3
   } cls_e;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   localparam logic [1:0] ALUOP_R = 2'b00;
   localparam logic [1:0] ALUOP_I = 2'b01;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier.
// Maps a 7-bit opcode to R-type, I-type or illegal.
module opcode_class
   import ctrl_pkg::*;
(
   input  logic [6:0] op,
   output cls_e       cls
);

   // classify the opcode field
   always_comb begin
      cls = CLS_ILL;
      case (op)
         OP_R:    cls = CLS_R;
         OP_I:    cls = CLS_I;
         default: cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer for a small RISC-V datapath.
// Moore FSM, registered opcode class and retired-instruction counter.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             halt_i,
   output logic             imem_req_o,
   input  logic             imem_ready_i,
   input  logic [6:0]       Op_i,
   output logic             IRWrite_o,
   output logic             PCWrite_o,
   output logic [1:0]       ALUOp_o,
   output logic             ALUSrc_o,
   output logic             RegWrite_o,
   output logic             busy_o,
   output logic             trap_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired_o
);

   state_e           state;
   state_e           next;
   cls_e             cls_d;
   cls_e             cls_q;
   logic [CNT_W-1:0] cnt;

   opcode_class u_cls (
      .op  (Op_i),
      .cls (cls_d)
   );

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= next;
   end

   // capture the opcode class while decoding
   always_ff @(posedge clk_i) begin
      if (rst_i)                  cls_q <= CLS_NONE;
      else if (state == S_DECODE) cls_q <= cls_d;
   end

   // retired-instruction counter, wraps silently
   always_ff @(posedge clk_i) begin
      if (rst_i)              cnt <= '0;
      else if (state == S_WB) cnt <= cnt + CNT_W'(1);
   end

   // next-state and Moore outputs; reset forces all outputs low
   always_comb begin
      next       = state;
      imem_req_o = 1'b0;
      IRWrite_o  = 1'b0;
      PCWrite_o  = 1'b0;
      ALUOp_o    = ALUOP_R;
      ALUSrc_o   = 1'b0;
      RegWrite_o = 1'b0;
      busy_o     = 1'b0;
      trap_o     = 1'b0;
      state_o    = state;
      retired_o  = cnt;
      case (state)
         S_IDLE: begin
            if (start_i) next = S_FETCH;
         end
         S_FETCH: begin
            busy_o     = 1'b1;
            imem_req_o = 1'b1;
            IRWrite_o  = imem_ready_i;
            if (imem_ready_i) next = S_DECODE;
         end
         S_DECODE: begin
            busy_o = 1'b1;
            if (cls_d == CLS_ILL) next = S_TRAP;
            else                  next = S_EXEC;
         end
         S_EXEC: begin
            busy_o = 1'b1;
            if (cls_q == CLS_I) begin
               ALUOp_o  = ALUOP_I;
               ALUSrc_o = 1'b1;
            end
            next = S_WB;
         end
         S_WB: begin
            busy_o     = 1'b1;
            RegWrite_o = 1'b1;
            PCWrite_o  = 1'b1;
            if (cls_q == CLS_I) begin
               ALUOp_o  = ALUOP_I;
               ALUSrc_o = 1'b1;
            end
            if (halt_i) next = S_IDLE;
            else        next = S_FETCH;
         end
         S_TRAP: begin
            trap_o = 1'b1;
         end
         default: begin
            next = S_IDLE;
         end
      endcase
      if (rst_i) begin
         next       = S_IDLE;
         imem_req_o = 1'b0;
         IRWrite_o  = 1'b0;
         PCWrite_o  = 1'b0;
         ALUOp_o    = ALUOP_R;
         ALUSrc_o   = 1'b0;
         RegWrite_o = 1'b0;
         busy_o     = 1'b0;
         trap_o     = 1'b0;
         state_o    = 3'd0;
         retired_o  = '0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
// Hand-computed expected outputs per cycle, compact summary at the end.
module tb_multicycle_ctrl;

   localparam logic [6:0] R_OP = 7'b0110011;
   localparam logic [6:0] I_OP = 7'b0010011;
   localparam logic [6:0] L_OP = 7'b0000011;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       halt = 1'b0;
   logic       imem_ready = 1'b0;
   logic [6:0] op = 7'd0;

   logic       imem_req;
   logic       irw;
   logic       pcw;
   logic [1:0] aluop;
   logic       alusrc;
   logic       rw;
   logic       busy;
   logic       trap;
   logic [2:0] st;
   logic [3:0] retired;

   logic [11:0] vec;

   int errs = 0;
   int checks = 0;
   int cyc = 0;

   multicycle_ctrl #(.CNT_W(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .halt_i       (halt),
      .imem_req_o   (imem_req),
      .imem_ready_i (imem_ready),
      .Op_i         (op),
      .IRWrite_o    (irw),
      .PCWrite_o    (pcw),
      .ALUOp_o      (aluop),
      .ALUSrc_o     (alusrc),
      .RegWrite_o   (rw),
      .busy_o       (busy),
      .trap_o       (trap),
      .state_o      (st),
      .retired_o    (retired)
   );

   assign vec = {st, busy, trap, imem_req, irw, pcw, rw, aluop, alusrc};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] ov(
      input logic [2:0] s, input logic b, input logic t,
      input logic req, input logic ir, input logic pc,
      input logic w, input logic [1:0] aop, input logic asrc);
      return {s, b, t, req, ir, pc, w, aop, asrc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string tag, input logic [11:0] exp);
      #1;
      chk(tag, {20'd0, vec}, {20'd0, exp});
   endtask

   // entered with the FSM in FETCH; leaves it one edge after WB
   task automatic run_instr(input logic [6:0] opc, input int waits,
                            input logic hlt);
      logic [1:0] aop;
      logic       asrc;
      aop  = (opc == I_OP) ? 2'b01 : 2'b00;
      asrc = (opc == I_OP);
      for (int w = 0; w <= waits; w++) begin
         imem_ready = (w == waits);
         op = opc;
         halt = hlt;
         look("fetch", ov(3'd1, 1, 0, 1, imem_ready, 0, 0, 2'b00, 0));
         tick();
      end
      imem_ready = 1'b1;
      look("decode", ov(3'd2, 1, 0, 0, 0, 0, 0, 2'b00, 0));
      tick();
      op = 7'b1111111;
      look("exec", ov(3'd3, 1, 0, 0, 0, 0, 0, aop, asrc));
      tick();
      look("wb", ov(3'd4, 1, 0, 0, 0, 1, 1, aop, asrc));
      tick();
      imem_ready = 1'b0;
      halt = 1'b0;
   endtask

   initial begin
      int c0;
      rst = 1'b1; start = 1'b1; halt = 1'b1; imem_ready = 1'b1; op = R_OP;
      tick(); tick();
      look("rst_out", 12'd0);
      chk("rst_ret", {28'd0, retired}, 32'd0);

      rst = 1'b0; start = 1'b1; halt = 1'b0; imem_ready = 1'b0;
      look("idle", 12'd0);
      tick();
      start = 1'b0;
      run_instr(R_OP, 0, 1'b0);
      chk("r_ret", {28'd0, retired}, 32'd1);
      look("r_next", ov(3'd1, 1, 0, 1, 0, 0, 0, 2'b00, 0));

      c0 = cyc;
      run_instr(I_OP, 3, 1'b1);
      chk("i_len", cyc - c0, 32'd7);
      chk("halt_ret", {28'd0, retired}, 32'd2);
      look("halt_idle", 12'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      imem_ready = 1'b1;
      op = L_OP;
      look("t_fetch", ov(3'd1, 1, 0, 1, 1, 0, 0, 2'b00, 0));
      tick();
      look("t_dec", ov(3'd2, 1, 0, 0, 0, 0, 0, 2'b00, 0));
      tick();
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         look("trap", ov(3'd5, 0, 1, 0, 0, 0, 0, 2'b00, 0));
         tick();
      end
      chk("trap_ret", {28'd0, retired}, 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; imem_ready = 1'b0;
      look("trap_rst", 12'd0);
      chk("trap_rst_ret", {28'd0, retired}, 32'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 17; i++) begin
         run_instr((i % 2) ? I_OP : R_OP, 0, i == 16);
         chk("wrap_ret", {28'd0, retired}, 32'((i + 1) % 16));
      end
      look("wrap_idle", 12'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      imem_ready = 1'b1;
      op = R_OP;
      look("rf_pre", ov(3'd1, 1, 0, 1, 1, 0, 0, 2'b00, 0));
      rst = 1'b1;
      look("rf_gate", 12'd0);
      tick();
      rst = 1'b0;
      imem_ready = 1'b0;
      look("rf_idle", 12'd0);
      chk("rf_ret", {28'd0, retired}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the retired-instruction counter.
REQ-002 Port clk_i, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 Port rst_i, input, 1 bit, reset; synchronous and active-high.
REQ-004 Port start_i, input, 1 bit, begins instruction sequencing from IDLE.
REQ-005 Port halt_i, input, 1 bit, requests a return to IDLE after the current instruction retires.
REQ-006 Port imem_req_o, output, 1 bit, instruction-fetch request.
REQ-007 Port imem_ready_i, input, 1 bit, fetch complete; instruction data is valid in the same cycle.
REQ-008 Port Op_i, input, 7 bits, opcode field of the instruction register (IR).
REQ-009 Port IRWrite_o, output, 1 bit, loads the IR.
REQ-010 Port PCWrite_o, output, 1 bit, advances the PC.
REQ-011 Port ALUOp_o, output, 2 bits, ALU operation class: 00 = R-type, 01 = I-type.
REQ-012 Port ALUSrc_o, output, 1 bit, ALU operand B select: 0 = register, 1 = immediate.
REQ-013 Port RegWrite_o, output, 1 bit, register-file write enable.
REQ-014 Port busy_o, output, 1 bit, sequencer active.
REQ-015 Port trap_o, output, 1 bit, an illegal opcode has been detected.
REQ-016 Port state_o, output, 3 bits, current state encoding for debug.
REQ-017 Port retired_o, output, CNT_W bits, count of retired instructions.

Function
REQ-018 The block SHALL be a Moore-style FSM with states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, TRAP=5.
REQ-019 In IDLE, start_i=1 SHALL move the FSM to FETCH; otherwise it SHALL stay in IDLE.
REQ-020 start_i SHALL be ignored in every state other than IDLE.
REQ-021 In FETCH, imem_req_o SHALL be 1 and SHALL stay 1 until imem_ready_i=1 is sampled.
REQ-022 In FETCH, IRWrite_o SHALL equal imem_ready_i.
REQ-023 FETCH SHALL move to DECODE on the cycle it samples imem_ready_i=1; otherwise it SHALL stay in FETCH.
REQ-024 In DECODE, Op_i SHALL be classified and the class registered: 0110011 = R-type, 0010011 = I-type, any other value = illegal.
REQ-025 From DECODE, a legal opcode SHALL move the FSM to EXEC and an illegal opcode SHALL move it to TRAP.
REQ-026 In EXEC and WB, ALUOp_o and ALUSrc_o SHALL reflect the registered class: R gives 00/0, I gives 01/1.
REQ-027 In all states other than EXEC and WB, ALUOp_o and ALUSrc_o SHALL be 00/0.
REQ-028 Changes on Op_i after DECODE SHALL NOT affect ALUOp_o or ALUSrc_o.
REQ-029 EXEC SHALL last exactly one cycle and then move to WB.
REQ-030 In WB, RegWrite_o and PCWrite_o SHALL each be 1 for exactly one cycle, and retired_o SHALL increment by 1.
REQ-031 retired_o SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-032 From WB, halt_i=1 SHALL move the FSM to IDLE; otherwise it SHALL move to FETCH.
REQ-033 An instruction SHALL take 4 cycles with zero-wait memory, and 4+N cycles with N wait cycles.
REQ-034 TRAP SHALL be sticky: trap_o=1, all enables 0, and only rst_i can leave it.
REQ-035 busy_o SHALL be 1 in FETCH, DECODE, EXEC and WB, and 0 in IDLE and TRAP.
REQ-036 imem_req_o, IRWrite_o, RegWrite_o and PCWrite_o SHALL be 0 outside the states that assert them above.
REQ-037 A stray imem_ready_i outside FETCH SHALL be ignored.

Reset
REQ-038 rst_i=1 at a clock edge SHALL, in any state including mid-fetch, force IDLE, set retired_o=0 and clear the registered class.
REQ-039 While in reset, every output SHALL be 0 and state_o SHALL be 000.
REQ-040 rst_i SHALL take priority over start_i, halt_i and imem_ready_i in the same cycle.

Structure
REQ-041 The state encoding, the opcode constants (OP_R=0110011, OP_I=0010011) and the ALUOp codes SHALL live in a shared package ctrl_pkg.
REQ-042 Opcode classification SHALL be a combinational sub-module opcode_class, which returns R, I or illegal.
REQ-043 The top level SHALL hold only the FSM, the class register and the counter.

Verification
REQ-044 Scenario: reset, start_i pulse, imem_ready_i held 1, Op_i=0110011 -> FETCH/DECODE/EXEC/WB on cycles 1-4; WB shows RegWrite_o=1, ALUOp_o=00, ALUSrc_o=0; retired_o=1.
REQ-045 Scenario: Op_i=0010011 with imem_ready_i delayed 3 cycles -> imem_req_o high for 4 cycles, IRWrite_o a single pulse; EXEC shows ALUOp_o=01, ALUSrc_o=1; instruction takes 7 cycles.
REQ-046 Scenario: Op_i=0000011 -> DECODE moves to TRAP, trap_o=1, busy_o=0, RegWrite_o never 1; start_i is ignored; only rst_i returns to IDLE.
REQ-047 Scenario: CNT_W=4, run 17 instructions -> retired_o reads 15, then 0, then 1.
REQ-048 Scenario: halt_i=1 during WB -> retired_o increments, next state IDLE, busy_o=0.
REQ-049 Scenario: rst_i asserted in FETCH while imem_ready_i=1 -> next state IDLE, IRWrite_o=0, retired_o=0.
